// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage.
package ifetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam int CNT_W = $clog2(FETCH_BUF_DEPTH + 1);
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry shift FIFO of fetched {pc, instr} pairs; head reads 0 when empty.
module fetch_fifo
    import ifetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       din,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);
    fetch_entry_t e0, e1;
    logic [CNT_W-1:0] wr;
    always_comb begin
        wr = count - CNT_W'(pop);
        head = (count != '0) ? e0 : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
            e0 <= '0;
            e1 <= '0;
        end else begin
            if (pop) e0 <= e1;
            // Write slot is computed after the pop shift, so push overrides e0 when it lands there.
            if (push) begin
                if (wr[0]) e1 <= din;
                else e0 <= din;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: PC, credit-limited imem issue and 1-cycle response capture into a 2-entry buffer.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_rEn,
    output logic [31:0] imem_rAddr,
    input  logic [31:0] imem_rData,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);
    logic [31:0] pc_q, inflight_pc_q;
    logic inflight_q, pop, push, issue;
    logic [CNT_W-1:0] count;
    logic [2:0] outstanding;
    fetch_entry_t head;
    always_comb begin
        if_valid = count != '0;
        pop = if_valid & if_ready;
        outstanding = 3'(count) + 3'(inflight_q) - 3'(pop);
        // Credit: buffered plus in-flight words never exceed the buffer depth.
        issue = rst_n & ~redirect_valid & (outstanding <= 3'(FETCH_BUF_DEPTH - 1));
        push = inflight_q & ~redirect_valid;
        imem_rEn = issue;
        imem_rAddr = pc_q;
        if_pc = head.pc;
        if_instr = head.instr;
    end
    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ('{pc: inflight_pc_q, instr: imem_rData}),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (count)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & ~32'h3;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q <= pc_q + PC_STEP;
            end
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed cycle-by-cycle checks of ifetch issue, buffering, redirect and reset.
module tb_ifetch;
    logic clk = 1'b0;
    logic rst_n, redirect_valid, if_ready;
    logic [31:0] redirect_pc;
    logic imem_rEn, if_valid;
    logic [31:0] imem_rAddr, imem_rData, if_pc, if_instr;
    logic rEn2, valid2;
    logic [31:0] rAddr2, rData2, pc2, instr2;
    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    ifetch dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rEn(imem_rEn), .imem_rAddr(imem_rAddr), .imem_rData(imem_rData),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_rEn(rEn2), .imem_rAddr(rAddr2), .imem_rData(rData2),
        .if_valid(valid2), .if_ready(1'b1), .if_pc(pc2), .if_instr(instr2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) + 32'h100;
    endfunction

    always @(posedge clk) begin
        if (imem_rEn) imem_rData <= memf(imem_rAddr);
        if (rEn2) rData2 <= memf(rAddr2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rp, input logic rn);
        @(posedge clk);
        #1;
        if_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rp;
        rst_n = rn;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, ".rEn"}, 32'(imem_rEn), 32'(en));
        check({tag, ".rAddr"}, imem_rAddr, addr);
        check({tag, ".valid"}, 32'(if_valid), 32'(v));
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, ins);
    endtask

    initial begin
        rst_n = 1'b0;
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #2;
        expect_out("reset", 0, 32'h0, 0, 32'h0, 32'h0);
        check("reset.rAddr2", rAddr2, 32'hFFFF_FFF8);
        check("reset.rEn2", 32'(rEn2), 32'h0);
        // Streaming from reset
        step(1, 0, 0, 1); expect_out("c0", 1, 32'h0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1); expect_out("c1", 1, 32'h4, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1); expect_out("c2", 1, 32'h8, 1, 32'h0, 32'h100);
        check("wrap.c2.pc", pc2, 32'hFFFF_FFF8);
        check("wrap.c2.instr", instr2, 32'h4000_00FE);
        // Back-pressure cycles 3-7
        step(0, 0, 0, 1); expect_out("c3", 0, 32'hC, 1, 32'h4, 32'h101);
        check("wrap.c3.pc", pc2, 32'hFFFF_FFFC);
        check("wrap.c3.instr", instr2, 32'h4000_00FF);
        step(0, 0, 0, 1); expect_out("c4", 0, 32'hC, 1, 32'h4, 32'h101);
        check("wrap.c4.pc", pc2, 32'h0);
        check("wrap.c4.instr", instr2, 32'h100);
        step(0, 0, 0, 1); expect_out("c5", 0, 32'hC, 1, 32'h4, 32'h101);
        check("wrap.c5.pc", pc2, 32'h4);
        check("wrap.c5.valid", 32'(valid2), 32'h1);
        step(0, 0, 0, 1); expect_out("c6", 0, 32'hC, 1, 32'h4, 32'h101);
        step(0, 0, 0, 1); expect_out("c7", 0, 32'hC, 1, 32'h4, 32'h101);
        step(1, 0, 0, 1); expect_out("c8", 1, 32'hC, 1, 32'h4, 32'h101);
        step(1, 0, 0, 1); expect_out("c9", 1, 32'h10, 1, 32'h8, 32'h102);
        step(1, 0, 0, 1); expect_out("c10", 1, 32'h14, 1, 32'hC, 32'h103);
        // Redirect with a buffered word and a fetch in flight, decode stalled
        step(0, 1, 32'h100, 1); expect_out("c11", 0, 32'h18, 1, 32'h10, 32'h104);
        step(1, 0, 0, 1); expect_out("c12", 1, 32'h100, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1); expect_out("c13", 1, 32'h104, 0, 32'h0, 32'h0);
        // Redirect coincident with a pop, unaligned target
        step(1, 1, 32'h102, 1); expect_out("c14", 0, 32'h108, 1, 32'h100, 32'h140);
        step(1, 0, 0, 1); expect_out("c15", 1, 32'h100, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1); expect_out("c16", 1, 32'h104, 0, 32'h0, 32'h0);
        // Fill the buffer, then reset mid-stream
        step(0, 0, 0, 1); expect_out("c17", 0, 32'h108, 1, 32'h100, 32'h140);
        step(0, 0, 0, 0); expect_out("c18", 0, 32'h108, 1, 32'h100, 32'h140);
        step(1, 0, 0, 1); expect_out("c19", 1, 32'h0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1); expect_out("c20", 1, 32'h4, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1); expect_out("c21", 1, 32'h8, 1, 32'h0, 32'h100);
        step(1, 0, 0, 1); expect_out("c22", 1, 32'hC, 1, 32'h4, 32'h101);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
